periph_fabric: RTL and testbench
================================

// Module: periph_fabric
// PURPOSE
//  Parametrised peripheral interconnect between the core data port and NUM_PERIPH memory-mapped slaves.
//  Replaces the fixed per-peripheral address decode at SoC top with a table-driven decoder.
//  Adds a registered request stage, a per-transaction timeout, and an error response for unmapped addresses.
//  A sticky error record of the first failing address is kept for the trap handler.
// PARAMETERS
//  NUM_PERIPH      4                       number of slave ports (1..16)
//  DATA_W          32                      data width
//  REGION_BITS     12                      log2 region size; uniform for all slaves
//  BASE_ADDRS      {40003000,..,40000000}  NUM_PERIPH*32 packed bases; slave k at [32k+:32], aligned to region
//  TIMEOUT_CYCLES  255                     WAIT cycles before abort (>=1)
//  ERR_RDATA       32'hDEAD_BEEF           rdata returned on error
// PORTS
//  clk          in   1                clock
//  rst          in   1                async reset, active-high
//  i_addr       in   32               host byte address
//  i_wdata      in   DATA_W           host write data
//  i_flag       in   3                host size/sign flag, passed through
//  i_we         in   1                write request, held until o_ready
//  i_re         in   1                read request, held until o_ready
//  o_rdata      out  DATA_W           read data, valid when o_ready
//  o_ready      out  1                one-cycle completion pulse
//  o_err        out  1                with o_ready: unmapped or timed out
//  o_p_sel      out  NUM_PERIPH       one-hot slave select
//  o_p_addr     out  REGION_BITS      offset within region
//  o_p_wdata    out  DATA_W           registered write data
//  o_p_flag     out  3                registered flag
//  o_p_we       out  1                registered write strobe
//  o_p_re       out  1                registered read strobe
//  i_p_rdata    in   NUM_PERIPH*DATA_W  slave k read data at [k*DATA_W+:DATA_W]
//  i_p_ready    in   NUM_PERIPH       slave k done
//  o_err_sticky out  1                set on first error, cleared only by rst
//  o_err_addr   out  32               address of first error
// BEHAVIOUR
//  Reset: all outputs 0, FSM=IDLE, timeout counter 0. Async assert aborts an in-flight access;
//   o_p_sel drops in the same cycle; no o_ready is issued for the aborted access.
//  FSM states and transitions:
//   IDLE: on (i_we|i_re), decode i_addr.
//    Hit slave k: latch addr/wdata/flag, set o_p_sel[k] and o_p_we/o_p_re, counter=0, go WAIT.
//    Miss: go RESP with err=1.
//   WAIT: i_p_ready[k] of the selected slave -> capture i_p_rdata[k], go RESP with err=0.
//    Else counter++; when counter==TIMEOUT_CYCLES-1 -> go RESP with err=1.
//    If ready and timeout coincide, ready wins.
//   RESP: o_ready=1 and o_err=err for exactly one cycle.
//    o_p_sel, o_p_we and o_p_re are already 0. Go IDLE.
//  Handshake and ordering:
//   o_ready for a request may be used by the host to present the next request in the following cycle.
//   A request seen in RESP is ignored; it is sampled next cycle in IDLE.
//   i_addr, i_wdata and i_flag are don't-care after the IDLE sample cycle.
//   i_p_ready from non-selected slaves is ignored, as is i_p_ready in IDLE or RESP.
//  Latency: hit with slave ready in its first WAIT cycle -> o_ready 2 cycles after request sample.
//   Miss -> 1 cycle. Timeout -> TIMEOUT_CYCLES+1 cycles.
//  Decode: slave k hits when i_addr[31:REGION_BITS]==BASE_ADDRS[32k+REGION_BITS+:32-REGION_BITS].
//   Overlapping regions: lowest k wins.
//  i_we & i_re together is treated as a write; i_re is ignored.
//  Error data: on err, o_rdata=ERR_RDATA; otherwise o_rdata holds the captured data during RESP and is 0 otherwise.
//  Error record: the first error after reset sets o_err_sticky and o_err_addr. Later errors do not update it.
//  Counter width: $clog2(TIMEOUT_CYCLES+1); it never wraps.
// STRUCTURE
//  periph_fabric_pkg: state enum {IDLE,WAIT,RESP}, default ERR_RDATA, function onehot_prio(vector).
//  Sub-module periph_addr_decode: combinational; addr -> one-hot hit vector, any_hit; lowest-index priority.
//  Top holds the FSM, request registers, timeout counter, rdata mux, and sticky error regs.
// TESTING
//  1 Read slave 2 (base 40002000, N=4), addr 40002008, ready on first WAIT cycle, rdata 0x1234_5678
//    -> o_p_sel=0100, o_p_addr=008; o_ready at +2 cycles; o_rdata=12345678; o_err=0.
//  2 Write addr 5000_0000 (unmapped) -> o_p_sel stays 0; o_ready+o_err at +1;
//    o_rdata=DEADBEEF; o_err_sticky=1; o_err_addr=50000000.
//  3 Read slave 0, slave never ready, TIMEOUT_CYCLES=4 -> o_ready+o_err at +5; o_p_sel cleared in RESP.
//    A second error then leaves o_err_addr unchanged.
//  4 Back-to-back: write slave 1 then read slave 3, presented the cycle after o_ready -> both complete.
//    Slave 3 ready asserted during the slave-1 transaction is ignored.
//  5 Slave 1 ready in the same cycle the counter hits its limit -> o_err=0 and data captured.
//    i_we&i_re together -> o_p_we=1, o_p_re=0.
//  6 rst asserted in WAIT -> o_p_sel=0 immediately; no o_ready.
//    After release, a new read completes normally.

Source files
------------

// File: rtl/periph_fabric_pkg.sv
// Shared types and helpers for the peripheral fabric.
//  - state_e           : transaction FSM states
//  - ERR_RDATA_DEFAULT : read data returned on an error response
//  - onehot_prio()     : keeps only the lowest set bit of a vector
package periph_fabric_pkg;

  localparam int          MAX_PERIPH        = 16;
  localparam logic [31:0] ERR_RDATA_DEFAULT = 32'hDEAD_BEEF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  // Two's-complement trick: v & -v isolates the lowest set bit.
  function automatic logic [MAX_PERIPH-1:0] onehot_prio(input logic [MAX_PERIPH-1:0] v);
    return v & (~v + MAX_PERIPH'(1));
  endfunction

endpackage

// File: rtl/periph_fabric_if.sv
// Bus bundle between the host core, the fabric and the slave peripherals.
//  Host side : i_addr, i_wdata, i_flag, i_we, i_re -> o_rdata, o_ready, o_err
//  Slave side: o_p_sel, o_p_addr, o_p_wdata, o_p_flag, o_p_we, o_p_re <- i_p_rdata, i_p_ready
//  master modport: host plus slave models (drives every i_* signal)
//  slave modport : the fabric itself (drives every o_* signal)
interface periph_fabric_if #(
  parameter int NUM_PERIPH  = 4,
  parameter int DATA_W      = 32,
  parameter int REGION_BITS = 12
);
  logic [31:0]                  i_addr;
  logic [DATA_W-1:0]            i_wdata;
  logic [2:0]                   i_flag;
  logic                         i_we;
  logic                         i_re;
  logic [DATA_W-1:0]            o_rdata;
  logic                         o_ready;
  logic                         o_err;
  logic [NUM_PERIPH-1:0]        o_p_sel;
  logic [REGION_BITS-1:0]       o_p_addr;
  logic [DATA_W-1:0]            o_p_wdata;
  logic [2:0]                   o_p_flag;
  logic                         o_p_we;
  logic                         o_p_re;
  logic [NUM_PERIPH*DATA_W-1:0] i_p_rdata;
  logic [NUM_PERIPH-1:0]        i_p_ready;

  modport master (
    output i_addr, i_wdata, i_flag, i_we, i_re, i_p_rdata, i_p_ready,
    input  o_rdata, o_ready, o_err, o_p_sel, o_p_addr, o_p_wdata, o_p_flag, o_p_we, o_p_re
  );

  modport slave (
    input  i_addr, i_wdata, i_flag, i_we, i_re, i_p_rdata, i_p_ready,
    output o_rdata, o_ready, o_err, o_p_sel, o_p_addr, o_p_wdata, o_p_flag, o_p_we, o_p_re
  );
endinterface

// File: rtl/periph_addr_decode.sv
// Combinational table-driven address decoder.
//  addr_hi_i : host address bits [31:REGION_BITS]
//  hit_o     : one-hot slave hit, lowest index wins on overlapping regions
//  any_hit_o : at least one region matched
module periph_addr_decode
  import periph_fabric_pkg::*;
#(
  parameter int                          NUM_PERIPH  = 4,
  parameter int                          REGION_BITS = 12,
  parameter logic [NUM_PERIPH*32-1:0]    BASE_ADDRS  = '0
) (
  input  logic [31-REGION_BITS:0] addr_hi_i,
  output logic [NUM_PERIPH-1:0]   hit_o,
  output logic                    any_hit_o
);

  logic [NUM_PERIPH-1:0] raw_hit;

  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and no latch is inferred.
    raw_hit = '0;
    for (int k = 0; k < NUM_PERIPH; k++) begin
      raw_hit[k] = (addr_hi_i == BASE_ADDRS[32*k+REGION_BITS +: 32-REGION_BITS]);
    end
    hit_o     = NUM_PERIPH'(onehot_prio(MAX_PERIPH'(raw_hit)));
    any_hit_o = |raw_hit;
  end

endmodule

// File: rtl/periph_fabric.sv
// Peripheral interconnect: registered request stage, table-driven decode,
// per-transaction timeout, error response for unmapped addresses, and a
// sticky record of the first failing address.
//  clk, rst     : clock, asynchronous active-high reset
//  bus          : host and slave signals (slave modport)
//  o_err_sticky : set by the first error after reset
//  o_err_addr   : address of that first error
module periph_fabric
  import periph_fabric_pkg::*;
#(
  parameter int                       NUM_PERIPH     = 4,
  parameter int                       DATA_W         = 32,
  parameter int                       REGION_BITS    = 12,
  parameter logic [NUM_PERIPH*32-1:0] BASE_ADDRS     = {32'h4000_3000, 32'h4000_2000,
                                                        32'h4000_1000, 32'h4000_0000},
  parameter int                       TIMEOUT_CYCLES = 255,
  parameter logic [DATA_W-1:0]        ERR_RDATA      = DATA_W'(ERR_RDATA_DEFAULT)
) (
  input  logic              clk,
  input  logic              rst,
  periph_fabric_if.slave    bus,
  output logic              o_err_sticky,
  output logic [31:0]       o_err_addr
);

  localparam int               CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  state_e                state_q, state_d;
  logic                  err_q, err_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [NUM_PERIPH-1:0] sel_q, sel_d;
  logic [31:0]           addr_q, addr_d;
  logic [DATA_W-1:0]     wdata_q, wdata_d;
  logic [2:0]            flag_q, flag_d;
  logic                  we_q, we_d;
  logic                  re_q, re_d;
  logic [DATA_W-1:0]     rdata_q, rdata_d;
  logic                  sticky_q, sticky_d;
  logic [31:0]           err_addr_q, err_addr_d;

  logic [NUM_PERIPH-1:0] hit;
  logic                  any_hit;
  logic                  sel_ready;
  logic [DATA_W-1:0]     sel_rdata;
  logic                  fail;
  logic [31:0]           fail_addr;

  periph_addr_decode #(
    .NUM_PERIPH (NUM_PERIPH),
    .REGION_BITS(REGION_BITS),
    .BASE_ADDRS (BASE_ADDRS)
  ) u_decode (
    .addr_hi_i(bus.i_addr[31:REGION_BITS]),
    .hit_o    (hit),
    .any_hit_o(any_hit)
  );

  // Only the selected slave's ready and data are observed.
  always_comb begin
    sel_ready = |(bus.i_p_ready & sel_q);
    sel_rdata = '0;
    for (int k = 0; k < NUM_PERIPH; k++) begin
      if (sel_q[k]) sel_rdata = sel_rdata | bus.i_p_rdata[k*DATA_W +: DATA_W];
    end
  end

  always_comb begin
    state_d    = state_q;
    err_d      = err_q;
    cnt_d      = cnt_q;
    sel_d      = sel_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    flag_d     = flag_q;
    we_d       = we_q;
    re_d       = re_q;
    rdata_d    = rdata_q;
    sticky_d   = sticky_q;
    err_addr_d = err_addr_q;
    fail       = 1'b0;
    fail_addr  = addr_q;

    unique case (state_q)
      IDLE: begin
        if (bus.i_we || bus.i_re) begin
          addr_d  = bus.i_addr;
          wdata_d = bus.i_wdata;
          flag_d  = bus.i_flag;
          if (any_hit) begin
            sel_d   = hit;
            we_d    = bus.i_we;
            re_d    = bus.i_re & ~bus.i_we;  // simultaneous we/re is a write
            cnt_d   = '0;
            err_d   = 1'b0;
            state_d = WAIT;
          end else begin
            err_d     = 1'b1;
            fail      = 1'b1;
            fail_addr = bus.i_addr;
            state_d   = RESP;
          end
        end
      end
      WAIT: begin
        // Ready is checked first so it wins over a coincident timeout.
        if (sel_ready) begin
          rdata_d = sel_rdata;
          err_d   = 1'b0;
          sel_d   = '0;
          we_d    = 1'b0;
          re_d    = 1'b0;
          state_d = RESP;
        end else if (cnt_q == CNT_LAST) begin
          err_d   = 1'b1;
          fail    = 1'b1;
          sel_d   = '0;
          we_d    = 1'b0;
          re_d    = 1'b0;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (fail && !sticky_q) begin
      sticky_d   = 1'b1;
      err_addr_d = fail_addr;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      err_q      <= 1'b0;
      cnt_q      <= '0;
      sel_q      <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      flag_q     <= '0;
      we_q       <= 1'b0;
      re_q       <= 1'b0;
      rdata_q    <= '0;
      sticky_q   <= 1'b0;
      err_addr_q <= '0;
    end else begin
      // NOTE: non-blocking assignments make every register update from pre-edge values, independent of statement order.
      state_q    <= state_d;
      err_q      <= err_d;
      cnt_q      <= cnt_d;
      sel_q      <= sel_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      flag_q     <= flag_d;
      we_q       <= we_d;
      re_q       <= re_d;
      rdata_q    <= rdata_d;
      sticky_q   <= sticky_d;
      err_addr_q <= err_addr_d;
    end
  end

  assign bus.o_ready   = (state_q == RESP);
  assign bus.o_err     = (state_q == RESP) && err_q;
  assign bus.o_rdata   = (state_q != RESP) ? '0 : (err_q ? ERR_RDATA : rdata_q);
  assign bus.o_p_sel   = sel_q;
  assign bus.o_p_addr  = addr_q[REGION_BITS-1:0];
  assign bus.o_p_wdata = wdata_q;
  assign bus.o_p_flag  = flag_q;
  assign bus.o_p_we    = we_q;
  assign bus.o_p_re    = re_q;
  assign o_err_sticky  = sticky_q;
  assign o_err_addr    = err_addr_q;

endmodule

// File: tb/tb_periph_fabric.sv
// Self-checking bench for periph_fabric (4 slaves, TIMEOUT_CYCLES=4).
// Table of transactions with expected results; a scoreboard queue holds the
// expectation from drive time until the fabric answers with o_ready.
module tb_periph_fabric;

  localparam int NP = 4;
  localparam int DW = 32;
  localparam int RB = 12;
  localparam int TO = 4;
  localparam int BUDGET = 20;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        err_sticky;
  logic [31:0] err_addr;

  periph_fabric_if #(.NUM_PERIPH(NP), .DATA_W(DW), .REGION_BITS(RB)) bus ();

  periph_fabric #(
    .NUM_PERIPH    (NP),
    .DATA_W        (DW),
    .REGION_BITS   (RB),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .o_err_sticky(err_sticky),
    .o_err_addr  (err_addr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [2:0]  flag;
    logic        we;
    logic        re;
    int          tgt;       // slave that owns the address, -1 for unmapped
    int          dly;       // WAIT cycles before target ready, -1 never
    logic [3:0]  noise;     // ready from non-selected slaves
    logic [31:0] p_rdata;
    logic [3:0]  exp_sel;
    logic        exp_we;
    logic        exp_re;
    logic        exp_err;
    logic [31:0] exp_rdata;
    int          exp_lat;
  } vec_t;

  int   n_pass  = 0;
  int   n_total = 0;
  vec_t sb[$];
  vec_t vecs[8];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else n_pass++;
  endtask

  function automatic vec_t mk(input logic [31:0] addr, input logic [31:0] wdata,
                              input logic [2:0] flag, input logic we, input logic re,
                              input int tgt, input int dly, input logic [3:0] noise,
                              input logic [31:0] p_rdata, input logic [3:0] exp_sel,
                              input logic exp_we, input logic exp_re, input logic exp_err,
                              input logic [31:0] exp_rdata, input int exp_lat);
    vec_t v;
    v.addr = addr; v.wdata = wdata; v.flag = flag; v.we = we; v.re = re;
    v.tgt = tgt; v.dly = dly; v.noise = noise; v.p_rdata = p_rdata;
    v.exp_sel = exp_sel; v.exp_we = exp_we; v.exp_re = exp_re;
    v.exp_err = exp_err; v.exp_rdata = exp_rdata; v.exp_lat = exp_lat;
    return v;
  endfunction

  task automatic run_vec(input vec_t t);
    vec_t       e;
    logic [3:0] rdy;
    bit         done = 1'b0;
    @(negedge clk);
    bus.i_addr  = t.addr;
    bus.i_wdata = t.wdata;
    bus.i_flag  = t.flag;
    bus.i_we    = t.we;
    bus.i_re    = t.re;
    for (int k = 0; k < NP; k++)
      bus.i_p_rdata[k*DW +: DW] = (k == t.tgt) ? t.p_rdata : (32'hBAD0_0000 | 32'(k));
    bus.i_p_ready = '0;
    sb.push_back(t);
    for (int cyc = 1; cyc <= BUDGET && !done; cyc++) begin
      @(negedge clk);
      if (cyc == 1) begin
        check($sformatf("p_sel %h", t.addr), bus.o_p_sel, t.exp_sel);
        if (t.exp_sel != '0) begin
          check($sformatf("p_addr %h", t.addr), bus.o_p_addr, t.addr[RB-1:0]);
          check($sformatf("p_we %h", t.addr), bus.o_p_we, t.exp_we);
          check($sformatf("p_re %h", t.addr), bus.o_p_re, t.exp_re);
          check($sformatf("p_flag %h", t.addr), bus.o_p_flag, t.flag);
          if (t.exp_we) check($sformatf("p_wdata %h", t.addr), bus.o_p_wdata, t.wdata);
        end
      end
      if (bus.o_ready) begin
        if (sb.size() == 0) begin
          n_total++;
          $display("FAIL spurious_ready: o_ready with empty scoreboard");
        end else begin
          e = sb.pop_front();
          check($sformatf("latency %h", e.addr), 64'(cyc), 64'(e.exp_lat));
          check($sformatf("err %h", e.addr), bus.o_err, e.exp_err);
          check($sformatf("rdata %h", e.addr), bus.o_rdata, e.exp_rdata);
          check($sformatf("sel_in_resp %h", e.addr), bus.o_p_sel, 4'b0000);
        end
        bus.i_we      = 1'b0;
        bus.i_re      = 1'b0;
        bus.i_p_ready = '0;
        done          = 1'b1;
      end else begin
        rdy = t.noise;
        if (t.dly >= 0 && cyc >= 1 + t.dly) rdy[t.tgt] = 1'b1;
        bus.i_p_ready = rdy;
      end
    end
    if (!done) begin
      n_total++;
      $display("FAIL no_ready %h: no o_ready within %0d cycles, required at %0d", t.addr, BUDGET, t.exp_lat);
      bus.i_we      = 1'b0;
      bus.i_re      = 1'b0;
      bus.i_p_ready = '0;
      sb.delete();
    end
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.i_addr = '0; bus.i_wdata = '0; bus.i_flag = '0; bus.i_we = 1'b0; bus.i_re = 1'b0;
    bus.i_p_rdata = '0; bus.i_p_ready = '0;

    //        addr           wdata          flag    we    re    tgt dly noise    p_rdata        sel      we    re    err   rdata          lat
    vecs[0] = mk(32'h4000_2008, 32'h0,         3'b010, 1'b0, 1'b1, 2, 0, 4'b0000, 32'h1234_5678, 4'b0100, 1'b0, 1'b1, 1'b0, 32'h1234_5678, 2);
    vecs[1] = mk(32'h5000_0000, 32'h1111_2222, 3'b000, 1'b1, 1'b0, -1, -1, 4'b0000, 32'h0,        4'b0000, 1'b0, 1'b0, 1'b1, 32'hDEAD_BEEF, 1);
    vecs[2] = mk(32'h4000_0010, 32'h0,         3'b001, 1'b0, 1'b1, 0, -1, 4'b0000, 32'h0,         4'b0001, 1'b0, 1'b1, 1'b1, 32'hDEAD_BEEF, 5);
    vecs[3] = mk(32'h4000_1004, 32'hA5A5_A5A5, 3'b101, 1'b1, 1'b0, 1, 1, 4'b1000, 32'h0000_0011, 4'b0010, 1'b1, 1'b0, 1'b0, 32'h0000_0011, 3);
    vecs[4] = mk(32'h4000_3FFC, 32'h0,         3'b100, 1'b0, 1'b1, 3, 0, 4'b0001, 32'hCAFE_F00D, 4'b1000, 1'b0, 1'b1, 1'b0, 32'hCAFE_F00D, 2);
    vecs[5] = mk(32'h4000_1020, 32'h0,         3'b011, 1'b0, 1'b1, 1, 3, 4'b0000, 32'h0BAD_C0DE, 4'b0010, 1'b0, 1'b1, 1'b0, 32'h0BAD_C0DE, 5);
    vecs[6] = mk(32'h4000_2100, 32'h5A5A_0000, 3'b110, 1'b1, 1'b1, 2, 0, 4'b0000, 32'h7654_3210, 4'b0100, 1'b1, 1'b0, 1'b0, 32'h7654_3210, 2);
    vecs[7] = mk(32'h4000_4000, 32'h0,         3'b000, 1'b0, 1'b1, -1, -1, 4'b0000, 32'h0,        4'b0000, 1'b0, 1'b0, 1'b1, 32'hDEAD_BEEF, 1);

    repeat (2) @(negedge clk);
    check("reset o_ready", bus.o_ready, 1'b0);
    check("reset o_err", bus.o_err, 1'b0);
    check("reset o_rdata", bus.o_rdata, 32'h0);
    check("reset o_p_sel", bus.o_p_sel, 4'b0000);
    check("reset o_p_we", bus.o_p_we, 1'b0);
    check("reset err_sticky", err_sticky, 1'b0);
    check("reset err_addr", err_addr, 32'h0);
    rst = 1'b0;

    run_vec(vecs[0]);
    run_vec(vecs[1]);
    check("sticky after miss", err_sticky, 1'b1);
    check("err_addr after miss", err_addr, 32'h5000_0000);
    run_vec(vecs[2]);
    check("err_addr after timeout", err_addr, 32'h5000_0000);
    for (int i = 3; i < 8; i++) run_vec(vecs[i]);
    check("err_addr kept", err_addr, 32'h5000_0000);

    // Reset while a read is waiting on a silent slave.
    @(negedge clk);
    bus.i_addr = 32'h4000_0000;
    bus.i_re   = 1'b1;
    bus.i_p_ready = '0;
    @(negedge clk);
    check("rst_seq sel in WAIT", bus.o_p_sel, 4'b0001);
    #2 rst = 1'b1;
    #1;
    check("rst_seq sel dropped", bus.o_p_sel, 4'b0000);
    check("rst_seq no ready", bus.o_ready, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check($sformatf("rst_seq held %0d ready", i), bus.o_ready, 1'b0);
    end
    bus.i_re = 1'b0;
    rst = 1'b0;
    check("rst_seq sticky cleared", err_sticky, 1'b0);
    run_vec(vecs[0]);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
